// File: rtl/blk2s_arb_if.sv
// Request/core/result/response bundle for the BLK2S round-robin arbiter.
// slave = arbiter side, master = requesters plus core side.
interface blk2s_arb_if #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned IN_WIDTH  = 256,
  parameter int unsigned TAG_DEPTH = 8
);
  localparam int unsigned CNT_W = $clog2(TAG_DEPTH) + 1;

  logic [NUM_REQ-1:0]          req_vld;
  logic [NUM_REQ-1:0]          req_rdy;
  logic [NUM_REQ*IN_WIDTH-1:0] req_data;
  logic                        core_vld;
  logic                        core_rdy;
  logic [IN_WIDTH-1:0]         core_data;
  logic                        res_vld;
  logic                        res_rdy;
  logic [7:0]                  res_ptr;
  logic [NUM_REQ-1:0]          rsp_vld;
  logic [NUM_REQ-1:0]          rsp_rdy;
  logic [7:0]                  rsp_ptr;
  logic [CNT_W-1:0]            inflight;
  logic                        busy;

  modport slave (
    input  req_vld, req_data, core_rdy, res_vld, res_ptr, rsp_rdy,
    output req_rdy, core_vld, core_data, res_rdy, rsp_vld, rsp_ptr, inflight, busy
  );

  modport master (
    output req_vld, req_data, core_rdy, res_vld, res_ptr, rsp_rdy,
    input  req_rdy, core_vld, core_data, res_rdy, rsp_vld, rsp_ptr, inflight, busy
  );
endinterface

// File: rtl/blk2s_arb.sv
// Round-robin arbiter sharing one BLK2S pipeline; in-order tag FIFO routes results back.
// Optional macro BLK2S_ARB_ERR_EN: adds sticky err and drops results that arrive with no tag.
module blk2s_arb #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned IN_WIDTH  = 256,
  parameter int unsigned TAG_DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef BLK2S_ARB_ERR_EN
  output logic         err,
`endif
  blk2s_arb_if.slave   bus
);
  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned PTR_W = $clog2(TAG_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic                 r_core_vld;
  logic [IN_WIDTH-1:0]  r_core_data;
  logic [IDX_W-1:0]     r_last;
  logic [IDX_W-1:0]     r_tag_mem [TAG_DEPTH];
  logic [PTR_W:0]       r_wr_ptr;
  logic [PTR_W:0]       r_rd_ptr;

  logic [IDX_W-1:0]     w_grant_idx;
  logic                 w_any_req;
  logic [IN_WIDTH-1:0]  w_win_data;
  logic [CNT_W-1:0]     w_inflight;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_load;
  logic                 w_pop;
  logic [IDX_W-1:0]     w_tag;
  logic [NUM_REQ-1:0]   w_req_rdy;
  logic [NUM_REQ-1:0]   w_rsp_vld;
  logic                 w_res_rdy;

  // Rotating priority: first valid requester after the last winner.
  always_comb begin
    w_grant_idx = '0;
    w_any_req   = 1'b0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      int idx;
      idx = (int'(r_last) + k) % int'(NUM_REQ);
      if (!w_any_req && bus.req_vld[idx]) begin
        w_any_req   = 1'b1;
        w_grant_idx = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    w_win_data = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (w_grant_idx == IDX_W'(i)) w_win_data = bus.req_data[i*IN_WIDTH +: IN_WIDTH];
    end
  end

  assign w_inflight = CNT_W'(r_wr_ptr - r_rd_ptr);
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  // Full is judged on current occupancy, so a same-cycle pop does not free a slot yet.
  assign w_full     = (w_inflight == CNT_W'(TAG_DEPTH));
  assign w_load     = rst_n & (~r_core_vld | bus.core_rdy) & w_any_req & ~w_full;
  assign w_tag      = r_tag_mem[r_rd_ptr[PTR_W-1:0]];

  always_comb begin
    w_req_rdy = '0;
    if (w_load) w_req_rdy[w_grant_idx] = 1'b1;
  end

  // Result steering to the head-of-queue requester.
  always_comb begin
    w_rsp_vld = '0;
    w_res_rdy = 1'b0;
    if (rst_n) begin
      if (!w_empty) begin
        w_rsp_vld[w_tag] = bus.res_vld;
        w_res_rdy        = bus.rsp_rdy[w_tag];
      end
`ifdef BLK2S_ARB_ERR_EN
      else begin
        w_res_rdy = bus.res_vld;
      end
`endif
    end
  end

  assign w_pop = bus.res_vld & w_res_rdy & ~w_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_core_vld <= 1'b0;
      r_last     <= IDX_W'(NUM_REQ - 1);
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      if (w_load) begin
        r_core_vld <= 1'b1;
        r_last     <= w_grant_idx;
        r_wr_ptr   <= r_wr_ptr + 1'b1;
      end else if (bus.core_rdy) begin
        r_core_vld <= 1'b0;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Datapath storage carries no reset; validity is tracked by r_core_vld and the pointers.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_core_data                      <= w_win_data;
      r_tag_mem[r_wr_ptr[PTR_W-1:0]]   <= w_grant_idx;
    end
  end

`ifdef BLK2S_ARB_ERR_EN
  logic r_err;
  always_ff @(posedge clk) begin
    if (!rst_n)                          r_err <= 1'b0;
    else if (bus.res_vld && w_empty)     r_err <= 1'b1;
  end
  assign err = r_err;
`endif

  assign bus.req_rdy   = w_req_rdy;
  assign bus.core_vld  = r_core_vld;
  assign bus.core_data = r_core_data;
  assign bus.res_rdy   = w_res_rdy;
  assign bus.rsp_vld   = w_rsp_vld;
  assign bus.rsp_ptr   = bus.res_ptr;
  assign bus.inflight  = w_inflight;
  assign bus.busy      = (w_inflight != '0) | r_core_vld;
endmodule

// File: tb/tb_blk2s_arb.sv
// Directed bench for blk2s_arb: grant order, backpressure, FIFO full, routing, reset.
module tb_blk2s_arb;
  localparam int unsigned NR = 4;
  localparam int unsigned IW = 256;
  localparam int unsigned TD = 8;

  logic clk = 1'b0;
  logic rst_n;
`ifdef BLK2S_ARB_ERR_EN
  logic err;
`endif
  int total = 0;
  int bad   = 0;

  blk2s_arb_if #(.NUM_REQ(NR), .IN_WIDTH(IW), .TAG_DEPTH(TD)) bus ();

  blk2s_arb #(.NUM_REQ(NR), .IN_WIDTH(IW), .TAG_DEPTH(TD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef BLK2S_ARB_ERR_EN
    .err   (err),
`endif
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] pat(input int i);
    logic [31:0] w;
    w = 32'hD000_0000 | 32'(i);
    return {8{w}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [IW-1:0] obs, input logic [IW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    bus.req_vld = '0;
    bus.res_vld = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    bus.req_vld  = '0;
    bus.core_rdy = 1'b0;
    bus.res_vld  = 1'b0;
    bus.res_ptr  = '0;
    bus.rsp_rdy  = '0;
    for (int i = 0; i < int'(NR); i++) bus.req_data[i*IW +: IW] = pat(i);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_core_vld", IW'(bus.core_vld), '0);
    chk("rst_inflight", IW'(bus.inflight), '0);
    chk("rst_busy",     IW'(bus.busy),     '0);
    chk("rst_rsp_vld",  IW'(bus.rsp_vld),  '0);
    chk("rst_res_rdy",  IW'(bus.res_rdy),  '0);
    chk("rst_req_rdy",  IW'(bus.req_rdy),  '0);

    // single requester 2
    bus.core_rdy = 1'b1;
    bus.req_vld  = 4'b0100;
    #1;
    chk("single_req_rdy", IW'(bus.req_rdy), IW'(4'b0100));
    tick();
    bus.req_vld = '0;
    chk("single_core_vld",  IW'(bus.core_vld), IW'(1));
    chk("single_core_data", bus.core_data, pat(2));
    chk("single_inflight",  IW'(bus.inflight), IW'(1));
    chk("single_busy",      IW'(bus.busy), IW'(1));
    tick();
    chk("single_core_drop", IW'(bus.core_vld), '0);
    bus.res_vld = 1'b1;
    bus.res_ptr = 8'h3C;
    bus.rsp_rdy = 4'b0100;
    #1;
    chk("single_rsp_vld", IW'(bus.rsp_vld), IW'(4'b0100));
    chk("single_rsp_ptr", IW'(bus.rsp_ptr), IW'(8'h3C));
    chk("single_res_rdy", IW'(bus.res_rdy), IW'(1));
    tick();
    bus.res_vld = 1'b0;
    chk("single_inflight0", IW'(bus.inflight), '0);
    chk("single_busy0",     IW'(bus.busy), '0);

    // fairness: all requesting, expect 0,1,2,3,0,1
    do_reset();
    bus.req_vld = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("fair_rdy%0d", k), IW'(bus.req_rdy), IW'(4'b0001 << (k % 4)));
      tick();
      chk($sformatf("fair_data%0d", k), bus.core_data, pat(k % 4));
    end
    bus.req_vld = '0;
    chk("fair_inflight", IW'(bus.inflight), IW'(6));

    // backpressure after first load
    do_reset();
    bus.req_vld = 4'b0001;
    #1;
    chk("bp_first_rdy", IW'(bus.req_rdy), IW'(4'b0001));
    tick();
    bus.core_rdy = 1'b0;
    bus.req_vld  = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("bp_req_rdy%0d", k), IW'(bus.req_rdy), '0);
      chk($sformatf("bp_core_vld%0d", k), IW'(bus.core_vld), IW'(1));
      chk($sformatf("bp_core_data%0d", k), bus.core_data, pat(0));
      chk($sformatf("bp_inflight%0d", k), IW'(bus.inflight), IW'(1));
      tick();
    end
    bus.core_rdy = 1'b1;
    #1;
    chk("bp_release_rdy", IW'(bus.req_rdy), IW'(4'b0010));
    tick();
    bus.req_vld = '0;
    chk("bp_release_data", bus.core_data, pat(1));
    chk("bp_release_inflight", IW'(bus.inflight), IW'(2));

    // FIFO full: exactly TAG_DEPTH loads with no results
    do_reset();
    bus.req_vld = 4'b1111;
    for (int k = 0; k < int'(TD); k++) begin
      #1;
      chk($sformatf("full_rdy%0d", k), IW'(bus.req_rdy), IW'(4'b0001 << (k % 4)));
      tick();
    end
    chk("full_inflight", IW'(bus.inflight), IW'(8));
    #1;
    chk("full_block", IW'(bus.req_rdy), '0);
    tick();
    bus.res_vld = 1'b1;
    bus.res_ptr = 8'h55;
    bus.rsp_rdy = 4'b1111;
    #1;
    chk("full_pop_rsp_vld", IW'(bus.rsp_vld), IW'(4'b0001));
    chk("full_pop_res_rdy", IW'(bus.res_rdy), IW'(1));
    chk("full_pop_no_load", IW'(bus.req_rdy), '0);
    tick();
    bus.res_vld = 1'b0;
    chk("full_after_pop", IW'(bus.inflight), IW'(7));
    #1;
    chk("full_next_load", IW'(bus.req_rdy), IW'(4'b0001));
    tick();
    bus.req_vld = '0;
    chk("full_refill", IW'(bus.inflight), IW'(8));
    chk("full_refill_data", bus.core_data, pat(0));

    // ordered routing 3,1,3
    do_reset();
    bus.req_vld = 4'b1000;
    #1;
    chk("ord_rdy_a", IW'(bus.req_rdy), IW'(4'b1000));
    tick();
    bus.req_vld = 4'b0010;
    #1;
    chk("ord_rdy_b", IW'(bus.req_rdy), IW'(4'b0010));
    tick();
    bus.req_vld = 4'b1000;
    #1;
    chk("ord_rdy_c", IW'(bus.req_rdy), IW'(4'b1000));
    tick();
    bus.req_vld = '0;
    chk("ord_inflight", IW'(bus.inflight), IW'(3));
    bus.res_vld = 1'b1;
    bus.res_ptr = 8'h01;
    bus.rsp_rdy = 4'b1111;
    #1;
    chk("ord_vld1", IW'(bus.rsp_vld), IW'(4'b1000));
    chk("ord_ptr1", IW'(bus.rsp_ptr), IW'(8'h01));
    tick();
    bus.res_ptr = 8'h02;
    bus.rsp_rdy = 4'b1101;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("ord_hold_vld%0d", k), IW'(bus.rsp_vld), IW'(4'b0010));
      chk($sformatf("ord_hold_rdy%0d", k), IW'(bus.res_rdy), '0);
      tick();
      chk($sformatf("ord_hold_inflight%0d", k), IW'(bus.inflight), IW'(2));
    end
    bus.rsp_rdy = 4'b1111;
    #1;
    chk("ord_vld2", IW'(bus.rsp_vld), IW'(4'b0010));
    chk("ord_ptr2", IW'(bus.rsp_ptr), IW'(8'h02));
    chk("ord_rdy2", IW'(bus.res_rdy), IW'(1));
    tick();
    bus.res_ptr = 8'h03;
    #1;
    chk("ord_vld3", IW'(bus.rsp_vld), IW'(4'b1000));
    chk("ord_ptr3", IW'(bus.rsp_ptr), IW'(8'h03));
    tick();
    bus.res_vld = 1'b0;
    chk("ord_drained", IW'(bus.inflight), '0);

    // reset with three requests in flight
    do_reset();
    bus.req_vld = 4'b0111;
    tick();
    tick();
    tick();
    bus.req_vld = '0;
    chk("mid_inflight3", IW'(bus.inflight), IW'(3));
    do_reset();
    #1;
    chk("mid_core_vld", IW'(bus.core_vld), '0);
    chk("mid_inflight", IW'(bus.inflight), '0);
    chk("mid_busy",     IW'(bus.busy), '0);
    bus.res_vld = 1'b1;
    bus.res_ptr = 8'hAA;
    bus.rsp_rdy = 4'b1111;
    #1;
    chk("mid_rsp_vld", IW'(bus.rsp_vld), '0);
`ifdef BLK2S_ARB_ERR_EN
    chk("mid_err_pre", IW'(err), '0);
    chk("mid_res_rdy", IW'(bus.res_rdy), IW'(1));
    tick();
    chk("mid_err", IW'(err), IW'(1));
`else
    chk("mid_res_rdy", IW'(bus.res_rdy), '0);
    tick();
`endif
    bus.res_vld = 1'b0;
    chk("mid_inflight_after", IW'(bus.inflight), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/blk2s_arb.md
Name: blk2s_arb

Overview:
- Round-robin arbiter that shares one BLK2S hash pipeline (BLK2S plus its post-reduction stage) among NUM_REQ requesters.
- Registers the granted request into a single issue stage that drives the core.
- Records the winner's index in an in-flight tag FIFO.
- Routes each returned 8-bit buf_ptr result back to the requester that issued it, in order.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
IN_WIDTH, 256, request payload width passed to the core
TAG_DEPTH, 8, max requests in flight (power of 2, 2..16)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_vld  in  NUM_REQ  per-requester request valid
req_rdy  out  NUM_REQ  per-requester request accept
req_data  in  NUM_REQ*IN_WIDTH  payloads; requester i at [i*IN_WIDTH +: IN_WIDTH]
core_vld  out  1  request valid to core
core_rdy  in  1  core accepts request
core_data  out  IN_WIDTH  payload to core
res_vld  in  1  core result valid
res_rdy  out  1  result accept to core
res_ptr  in  8  core result (buf_ptr)
rsp_vld  out  NUM_REQ  one-hot response valid
rsp_rdy  in  NUM_REQ  per-requester response accept
rsp_ptr  out  8  response data, shared by all requesters
inflight  out  $clog2(TAG_DEPTH)+1  tag FIFO occupancy
busy  out  1  high when inflight != 0 or core_vld

Behaviour:
- Reset: one clock, synchronous active-low (rst_n sampled on clk edge).
- Reset values: core_vld=0, inflight=0, busy=0, rsp_vld=0, res_rdy=0, req_rdy=0, tag FIFO rd/wr pointers=0, rr pointer last=NUM_REQ-1 (req0 wins first). core_data is not reset.
- Reset mid-operation: in-flight tags are discarded. Results arriving afterwards are treated as results on an empty FIFO.
- Load condition: load = (~core_vld | core_rdy) & (|req_vld) & (inflight != TAG_DEPTH).
- A full FIFO blocks load even if a pop occurs in the same cycle.
- Grant: the first set req_vld bit searching from last+1 upward, wrapping modulo NUM_REQ. Purely combinational from req_vld and last.
- req_rdy[i] = load & grant[i]. Requester handshake is req_vld[i] & req_rdy[i].
- On load, all in the same edge:
  - core_data <= winner's payload; core_vld <= 1;
  - last <= winner index;
  - winner index pushed into the tag FIFO.
- If core_vld & core_rdy with no load, core_vld <= 0.
- core_vld/core_data hold stable while core_vld & ~core_rdy.
- Latency: request accepted at edge N; core_vld is high in the cycle after edge N. Back-to-back issue gives 1 request/cycle when core_rdy stays high.
- Response routing, tag = FIFO head, FIFO non-empty:
  - rsp_vld[tag] = res_vld; all other rsp_vld bits are 0;
  - rsp_ptr = res_ptr (combinational);
  - res_rdy = rsp_rdy[tag].
- Response handshake (res_vld & res_rdy) pops the FIFO.
- FIFO empty: rsp_vld = 0, res_rdy = 0 (core stalls).
- inflight: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Pointer wrap: tag FIFO pointers carry one extra bit to distinguish full from empty.
- Starvation bound: a requester held valid is granted within NUM_REQ loads.
- Results return in issue order; the core pipeline is in-order.

Optional Feature:
- Macro: BLK2S_ARB_ERR_EN.
- Defined: adds output port err (1 bit, reset 0).
  - res_vld with an empty FIFO forces res_rdy=1, drops the result, and sets err sticky until reset.
  - A push with inflight==TAG_DEPTH cannot occur by construction.
- Undefined: no err port. Results on an empty FIFO stall (res_rdy=0) as specified above.

Test Plan:
- Single requester: req_vld=4'b0100 with data A, core_rdy=1 -> req_rdy[2] at cycle 0, core_vld and core_data=A at cycle 1, inflight=1. Then res_vld with res_ptr=8'h3C and rsp_rdy[2]=1 -> rsp_vld=4'b0100, rsp_ptr=8'h3C, inflight=0.
- Fairness: all four req_vld held high, core_rdy=1 -> grant order 0,1,2,3,0,1 on consecutive cycles.
- Backpressure: core_rdy=0 for 5 cycles after the first load -> core_vld and core_data stable, req_rdy all 0, inflight stays 1.
- FIFO full: TAG_DEPTH=8, core_rdy=1, no results -> exactly 8 loads, then req_rdy=0 with inflight=8. One result pop -> next load occurs the following cycle, not the same one.
- Ordered routing: issue from requesters 3,1,3, return ptrs 8'h01,8'h02,8'h03 -> rsp_vld sequence 1000,0010,1000 with matching ptrs. rsp_rdy[1]=0 for 2 cycles -> res_rdy=0 and the FIFO head is held.
- Sync reset mid-flight with inflight=3: after rst_n low for one edge, outputs are at reset values. With BLK2S_ARB_ERR_EN, a subsequent res_vld -> res_rdy=1 and err=1.
